// File: rtl/rom_access_ctrl_pkg.sv
// Shared widths, FSM state encoding and the byte-merge helper for the
// expansion ROM access controller.
package rom_access_ctrl_pkg;

  localparam int ROM_AW = 9;
  localparam int ROM_DW = 32;
  localparam int ROM_BW = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Lanes with their enable set take the new byte; the rest keep what the ROM held.
  function automatic logic [ROM_DW-1:0] merge_bytes(
    input logic [ROM_BW-1:0] be,
    input logic [ROM_DW-1:0] wdata,
    input logic [ROM_DW-1:0] rdata
  );
    logic [ROM_DW-1:0] merged;
    merged = rdata;
    for (int i = 0; i < ROM_BW; i++) begin
      if (be[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rom_rr_arb.sv
// Two-way arbiter for the ROM: strict A priority or round-robin using a
// last-served pointer that only moves when a transaction is accepted.
module rom_rr_arb #(
  parameter int A_PRIO = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic a_req_i,
  input  logic b_req_i,
  input  logic accept_i,
  output logic grant_a_o,
  output logic grant_b_o
);

  logic last_b_q;

  // Pointer starts at B so that A takes the very first tie.
  always_comb begin
    grant_a_o = a_req_i & ((A_PRIO != 0) | ~b_req_i | last_b_q);
    grant_b_o = b_req_i & ~grant_a_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_b_q <= 1'b1;
    end else if (accept_i) begin
      last_b_q <= grant_b_o;
    end
  end

endmodule

// File: rtl/rom_access_ctrl.sv
// Sequences reads, full writes and read-modify-write partial writes from two
// requesters onto the single-wren 512x32 expansion ROM.
module rom_access_ctrl
  import rom_access_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int A_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_req_i,
  input  logic [ROM_AW-1:0] a_addr_i,
  output logic              a_ack_o,
  output logic [ROM_DW-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ROM_BW-1:0] b_be_i,
  input  logic [ROM_AW-1:0] b_addr_i,
  input  logic [ROM_DW-1:0] b_wdata_i,
  output logic              b_ack_o,
  output logic [ROM_DW-1:0] b_rdata_o,
  output logic              b_err_o,
  input  logic              wr_lock_i,
  output logic              rom_enable_o,
  output logic              rom_wren_o,
  output logic [ROM_AW-1:0] rom_address_o,
  output logic [ROM_DW-1:0] rom_dinp_o,
  input  logic [ROM_DW-1:0] rom_dout_i
);

  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  state_e            state_q;
  logic [1:0]        wait_cnt_q;
  logic              is_b_q;
  logic              we_q;
  logic [ROM_BW-1:0] be_q;
  logic [ROM_DW-1:0] wdata_q;

  logic              a_ack_q;
  logic [ROM_DW-1:0] a_rdata_q;
  logic              b_ack_q;
  logic [ROM_DW-1:0] b_rdata_q;
  logic              b_err_q;
  logic              rom_enable_q;
  logic              rom_wren_q;
  logic [ROM_AW-1:0] rom_address_q;
  logic [ROM_DW-1:0] rom_dinp_q;

  logic grant_a;
  logic grant_b;
  logic accept;

  assign accept = (state_q == ST_IDLE) & (a_req_i | b_req_i);

  rom_rr_arb #(
    .A_PRIO(A_PRIO)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .a_req_i  (a_req_i),
    .b_req_i  (b_req_i),
    .accept_i (accept),
    .grant_a_o(grant_a),
    .grant_b_o(grant_b)
  );

  // Strobes default low every cycle; only the transition into ISSUE/WRITE
  // raises the ROM strobes and only the transition into DONE raises an ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      is_b_q        <= 1'b0;
      we_q          <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      a_ack_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_ack_q       <= 1'b0;
      b_rdata_q     <= '0;
      b_err_q       <= 1'b0;
      rom_enable_q  <= 1'b0;
      rom_wren_q    <= 1'b0;
      rom_address_q <= '0;
      rom_dinp_q    <= '0;
    end else begin
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      b_err_q      <= 1'b0;
      rom_enable_q <= 1'b0;
      rom_wren_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          wait_cnt_q <= '0;
          if (grant_a) begin
            is_b_q        <= 1'b0;
            we_q          <= 1'b0;
            rom_address_q <= a_addr_i;
            rom_enable_q  <= 1'b1;
            state_q       <= ST_ISSUE;
          end else if (grant_b) begin
            is_b_q  <= 1'b1;
            we_q    <= b_we_i;
            be_q    <= b_be_i;
            wdata_q <= b_wdata_i;
            if (!b_we_i) begin
              rom_address_q <= b_addr_i;
              rom_enable_q  <= 1'b1;
              state_q       <= ST_ISSUE;
            end else if (b_be_i == '0) begin
              b_ack_q <= 1'b1;
              state_q <= ST_DONE;
            end else if (wr_lock_i) begin
              b_ack_q <= 1'b1;
              b_err_q <= 1'b1;
              state_q <= ST_DONE;
            end else if (b_be_i == '1) begin
              rom_address_q <= b_addr_i;
              rom_dinp_q    <= b_wdata_i;
              rom_enable_q  <= 1'b1;
              rom_wren_q    <= 1'b1;
              state_q       <= ST_WRITE;
            end else begin
              rom_address_q <= b_addr_i;
              rom_enable_q  <= 1'b1;
              state_q       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          // The merge uses rom_dout directly on the capture edge of a partial write.
          if (wait_cnt_q == LAST_WAIT) begin
            if (is_b_q && we_q) begin
              rom_dinp_q   <= merge_bytes(be_q, wdata_q, rom_dout_i);
              rom_enable_q <= 1'b1;
              rom_wren_q   <= 1'b1;
              state_q      <= ST_WRITE;
            end else if (is_b_q) begin
              b_rdata_q <= rom_dout_i;
              b_ack_q   <= 1'b1;
              state_q   <= ST_DONE;
            end else begin
              a_rdata_q <= rom_dout_i;
              a_ack_q   <= 1'b1;
              state_q   <= ST_DONE;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        ST_WRITE: begin
          b_ack_q <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_ack_o       = a_ack_q;
  assign a_rdata_o     = a_rdata_q;
  assign b_ack_o       = b_ack_q;
  assign b_rdata_o     = b_rdata_q;
  assign b_err_o       = b_err_q;
  assign rom_enable_o  = rom_enable_q;
  assign rom_wren_o    = rom_wren_q;
  assign rom_address_o = rom_address_q;
  assign rom_dinp_o    = rom_dinp_q;

endmodule
